// File: rtl/rob_flush_pkg.sv
// Shared types, default sizing and slot arithmetic for the flushable reorder buffer.
package rob_flush_pkg;

    localparam int ROB_DATA_W    = 32;
    localparam int ROB_DEPTH     = 16;
    localparam int ROB_INS_COUNT = 4;
    localparam int ROB_EXT_COUNT = 4;
    localparam int ROB_WR_COUNT  = 4;
    localparam int ROB_SLOT_W    = $clog2(ROB_DEPTH);

    typedef logic [ROB_SLOT_W-1:0] slot_t;

    typedef struct packed {
        logic [ROB_DATA_W-1:0] data;
        logic                  done;
        logic                  exc;
    } rob_entry_t;

    // Number of steps from 'from' forward to 'to' on a ring of 'depth' (power of two) slots.
    function automatic int unsigned slot_dist(input int unsigned from,
                                              input int unsigned to,
                                              input int unsigned depth);
        return (to - from) & (depth - 1);
    endfunction

endpackage

// File: rtl/rob_flush_head_scan.sv
// Prefix chain over the head entries: an entry is extractable only if every older
// head entry is extractable and none of them raised an exception.
module rob_flush_head_scan #(
    parameter int EXT_COUNT = 4
) (
    input  logic [EXT_COUNT-1:0] i_ready,
    input  logic [EXT_COUNT-1:0] i_exc,
    output logic [EXT_COUNT-1:0] o_valid,
    output logic [EXT_COUNT-1:0] o_exc
);

    // Walk from the oldest head entry, stopping after the first exception.
    always_comb begin
        logic w_chain;
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        o_valid = '0;
        o_exc   = '0;
        w_chain = 1'b1;
        for (int i = 0; i < EXT_COUNT; i++) begin
            o_valid[i] = w_chain & i_ready[i];
            o_exc[i]   = o_valid[i] & i_exc[i];
            w_chain    = o_valid[i] & ~i_exc[i];
        end
    end

endmodule

// File: rtl/rob_flush.sv
// Reorder buffer with in-order reserve, out-of-order result writes, in-order
// extraction stopped by exceptions, partial flush of younger entries and full flush.
module rob_flush
    import rob_flush_pkg::*;
#(
    parameter int DATA_W    = ROB_DATA_W,
    parameter int DEPTH     = ROB_DEPTH,
    parameter int INS_COUNT = ROB_INS_COUNT,
    parameter int EXT_COUNT = ROB_EXT_COUNT,
    parameter int WR_COUNT  = ROB_WR_COUNT,
    parameter int SLOT_W    = $clog2(DEPTH),
    parameter int RC_W      = (INS_COUNT > 1) ? $clog2(INS_COUNT) : 1,
    parameter int CC_W      = (EXT_COUNT > 1) ? $clog2(EXT_COUNT) : 1
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              reserve,
    input  logic [RC_W-1:0]                   reserve_count,
    output logic [INS_COUNT-1:0][SLOT_W-1:0]  reserved_slots,
    input  logic [WR_COUNT-1:0]               write_valid,
    input  logic [WR_COUNT-1:0][SLOT_W-1:0]   write_slot,
    input  logic [WR_COUNT-1:0][DATA_W-1:0]   write_data,
    input  logic [WR_COUNT-1:0]               write_exc,
    input  logic                              consume,
    input  logic [CC_W-1:0]                   consume_count,
    output logic [EXT_COUNT-1:0][DATA_W-1:0]  slot_data,
    output logic [EXT_COUNT-1:0]              slot_valid,
    output logic [EXT_COUNT-1:0]              slot_exc,
    input  logic                              flush,
    input  logic [SLOT_W-1:0]                 flush_slot,
    input  logic                              flush_all,
    output logic                              empty,
    output logic                              full,
    output logic [SLOT_W:0]                   used_count
);

    logic [SLOT_W-1:0] r_ins_ptr, r_ext_ptr;
    logic [SLOT_W:0]   r_used;
    logic              r_empty, r_full;
    logic [DEPTH-1:0]  r_alloc, r_done, r_exc;
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [SLOT_W-1:0]    w_ins_nxt, w_ext_nxt;
    logic [SLOT_W:0]      w_used_nxt;
    logic [DEPTH-1:0]     w_alloc_nxt, w_done_nxt, w_exc_nxt;
    logic                 w_do_res, w_do_con;
    logic [EXT_COUNT-1:0] w_head_ready, w_head_exc;

    // Next-state for pointers, occupancy and per-slot status bits.
    always_comb begin
        int unsigned n_res, n_con, flush_age, age;
        n_res     = 32'(reserve_count) + 1;
        n_con     = 32'(consume_count) + 1;
        w_do_res  = reserve && !r_full && !flush && !flush_all;
        w_do_con  = consume && !flush_all;
        flush_age = slot_dist(32'(r_ext_ptr), 32'(flush_slot), DEPTH);
        if (!w_do_con) n_con = 0;
        if (!w_do_res) n_res = 0;

        w_ext_nxt = r_ext_ptr + SLOT_W'(n_con);

        if (flush_all) begin
            w_ins_nxt  = r_ext_ptr;
            w_used_nxt = '0;
        end else if (flush) begin
            w_ins_nxt  = flush_slot + SLOT_W'(1);
            w_used_nxt = (SLOT_W+1)'(flush_age + 1 - n_con);
        end else begin
            w_ins_nxt  = r_ins_ptr + SLOT_W'(n_res);
            w_used_nxt = (SLOT_W+1)'(32'(r_used) + n_res - n_con);
        end

        w_alloc_nxt = r_alloc;
        w_done_nxt  = r_done;
        w_exc_nxt   = r_exc;
        for (int j = 0; j < DEPTH; j++) begin
            age = slot_dist(32'(r_ext_ptr), 32'(j), DEPTH);
            // Ascending port order lets the highest-numbered port win a shared slot.
            for (int p = 0; p < WR_COUNT; p++) begin
                if (write_valid[p] && r_alloc[j] && (write_slot[p] == SLOT_W'(j))) begin
                    w_done_nxt[j] = 1'b1;
                    w_exc_nxt[j]  = write_exc[p];
                end
            end
            if (age < n_con)
                w_alloc_nxt[j] = 1'b0;
            if (flush && (age > flush_age) && (age < 32'(r_used)))
                w_alloc_nxt[j] = 1'b0;
            if (slot_dist(32'(r_ins_ptr), 32'(j), DEPTH) < n_res) begin
                w_alloc_nxt[j] = 1'b1;
                w_done_nxt[j]  = 1'b0;
                w_exc_nxt[j]   = 1'b0;
            end
            if (flush_all)
                w_alloc_nxt[j] = 1'b0;
        end
    end

    // Control state register; empty/full/used_count are registered together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ins_ptr <= '0;
            r_ext_ptr <= '0;
            r_used    <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_alloc   <= '0;
            r_done    <= '0;
            r_exc     <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_ins_ptr <= w_ins_nxt;
            r_ext_ptr <= w_ext_nxt;
            r_used    <= w_used_nxt;
            r_empty   <= (w_used_nxt == '0);
            r_full    <= (32'(w_used_nxt) > 32'(DEPTH - INS_COUNT));
            r_alloc   <= w_alloc_nxt;
            r_done    <= w_done_nxt;
            r_exc     <= w_exc_nxt;
        end
    end

    // Result payload storage; later ports overwrite earlier ones on a shared slot.
    // NOTE: payload RAM has no reset; it is only observed behind alloc/done, which are reset.
    always_ff @(posedge clock) begin
        for (int p = 0; p < WR_COUNT; p++) begin
            if (write_valid[p] && r_alloc[write_slot[p]])
                r_data[write_slot[p]] <= write_data[p];
        end
    end

    // Gather head entries and expose the slots the next reservation would take.
    always_comb begin
        logic [SLOT_W-1:0] idx;
        for (int i = 0; i < INS_COUNT; i++)
            reserved_slots[i] = r_ins_ptr + SLOT_W'(i);
        for (int i = 0; i < EXT_COUNT; i++) begin
            idx             = r_ext_ptr + SLOT_W'(i);
            w_head_ready[i] = r_alloc[idx] & r_done[idx];
            w_head_exc[i]   = r_exc[idx];
            slot_data[i]    = r_data[idx];
        end
    end

    rob_flush_head_scan #(
        .EXT_COUNT (EXT_COUNT)
    ) u_head_scan (
        .i_ready (w_head_ready),
        .i_exc   (w_head_exc),
        .o_valid (slot_valid),
        .o_exc   (slot_exc)
    );

    assign empty      = r_empty;
    assign full       = r_full;
    assign used_count = r_used;

    // Retiring an entry that is not extractable is a requester protocol error.
    a_consume_valid: assert property (@(posedge clock) disable iff (!reset_n)
        (consume && !flush_all) |-> slot_valid[consume_count]);

endmodule

// File: tb/tb_rob_flush.sv
// Self-checking bench: directed scenarios then random traffic against a queue model.
module tb_rob_flush;
    import rob_flush_pkg::*;

    localparam int D  = 16;
    localparam int NI = 4;
    localparam int NE = 4;
    localparam int NW = 4;
    localparam int SW = 4;

    logic clock = 1'b0;
    logic reset_n;
    logic reserve;
    logic [1:0] reserve_count;
    logic [NI-1:0][SW-1:0] reserved_slots;
    logic [NW-1:0] write_valid;
    logic [NW-1:0][SW-1:0] write_slot;
    logic [NW-1:0][31:0] write_data;
    logic [NW-1:0] write_exc;
    logic consume;
    logic [1:0] consume_count;
    logic [NE-1:0][31:0] slot_data;
    logic [NE-1:0] slot_valid, slot_exc;
    logic flush;
    logic [SW-1:0] flush_slot;
    logic flush_all;
    logic empty, full;
    logic [SW:0] used_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          slot;
        bit          done;
        bit          exc;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];
    int m_ext = 0;

    always #5 clock = ~clock;

    rob_flush dut (
        .clock(clock), .reset_n(reset_n),
        .reserve(reserve), .reserve_count(reserve_count), .reserved_slots(reserved_slots),
        .write_valid(write_valid), .write_slot(write_slot), .write_data(write_data), .write_exc(write_exc),
        .consume(consume), .consume_count(consume_count),
        .slot_data(slot_data), .slot_valid(slot_valid), .slot_exc(slot_exc),
        .flush(flush), .flush_slot(flush_slot), .flush_all(flush_all),
        .empty(empty), .full(full), .used_count(used_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        reserve = 0; reserve_count = 0; write_valid = '0; write_slot = '0;
        write_data = '0; write_exc = '0; consume = 0; consume_count = 0;
        flush = 0; flush_slot = '0; flush_all = 0;
    endtask

    task automatic wr(input int p, input int slot, input logic [31:0] d, input bit e);
        write_valid[p] = 1'b1; write_slot[p] = SW'(slot); write_data[p] = d; write_exc[p] = e;
    endtask

    // Extractable head entries: done in order, stopping after the first exception.
    function automatic void m_heads(output logic [NE-1:0] v, output logic [NE-1:0] e);
        bit chain = 1;
        v = '0; e = '0;
        for (int i = 0; i < NE; i++) begin
            if (chain && i < mq.size() && mq[i].done) begin
                v[i] = 1'b1; e[i] = mq[i].exc; chain = !mq[i].exc;
            end else chain = 0;
        end
    endfunction

    function automatic int m_nvalid();
        logic [NE-1:0] v, e;
        int n = 0;
        m_heads(v, e);
        for (int i = 0; i < NE; i++) if (v[i]) n++;
        return n;
    endfunction

    // Apply the inputs present at this edge to the model.
    task automatic model_edge();
        int pre_size = mq.size();
        int ins_pre  = (m_ext + pre_size) % D;
        bit pre_full = pre_size > D - NI;
        for (int p = 0; p < NW; p++)
            if (write_valid[p])
                foreach (mq[k])
                    if (mq[k].slot == int'(write_slot[p])) begin
                        mq[k].done = 1; mq[k].exc = write_exc[p]; mq[k].data = write_data[p];
                    end
        if (flush_all) begin
            mq.delete();
            return;
        end
        if (flush) begin
            int age = (int'(flush_slot) - m_ext + D) % D;
            while (mq.size() > age + 1) void'(mq.pop_back());
        end
        if (consume) begin
            for (int i = 0; i <= int'(consume_count); i++) void'(mq.pop_front());
            m_ext = (m_ext + int'(consume_count) + 1) % D;
        end
        if (reserve && !pre_full && !flush)
            for (int i = 0; i <= int'(reserve_count); i++) begin
                ent_t n;
                n.slot = (ins_pre + i) % D; n.done = 0; n.exc = 0; n.data = '0;
                mq.push_back(n);
            end
    endtask

    task automatic check_all();
        logic [NE-1:0] v, e;
        check("used_count", used_count, mq.size());
        check("empty", empty, mq.size() == 0);
        check("full", full, mq.size() > D - NI);
        for (int i = 0; i < NI; i++)
            check($sformatf("reserved_slots[%0d]", i), reserved_slots[i], (m_ext + mq.size() + i) % D);
        m_heads(v, e);
        check("slot_valid", slot_valid, v);
        check("slot_exc", slot_exc, e);
        for (int i = 0; i < NE; i++)
            if (v[i]) check($sformatf("slot_data[%0d]", i), slot_data[i], mq[i].data);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        clear_inputs();
        check_all();
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_used", used_count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", slot_valid, 0);
        check("rst_exc", slot_exc, 0);
        check_all();
        #10 reset_n = 1'b1;

        // Reserve four from reset.
        check("first_slots", reserved_slots, 16'h3210);
        reserve = 1; reserve_count = 3; step();
        check("res4_used", used_count, 4);
        check("res4_empty", empty, 0);

        // Out-of-order completion.
        wr(0, 2, 32'h22, 0); wr(1, 0, 32'h00, 0); step();
        check("ooo_valid_a", slot_valid, 4'b0001);
        wr(0, 1, 32'h11, 0); wr(1, 3, 32'h33, 0); step();
        check("ooo_valid_b", slot_valid, 4'b1111);
        consume = 1; consume_count = 3; step();
        check("drain_used", used_count, 0);
        check("drain_ptr", reserved_slots[0], 4);

        // Exception stops extraction (slots 4..7, exception on the second).
        reserve = 1; reserve_count = 3; step();
        for (int p = 0; p < 4; p++) wr(p, 4 + p, 32'hA0 + p, p == 1);
        step();
        check("exc_valid", slot_valid, 4'b0011);
        check("exc_flag", slot_exc, 4'b0010);
        consume = 1; consume_count = 1; step();
        check("exc_head", slot_data[0], 32'hA2);
        consume = 1; consume_count = 1; step();

        // Partial flush: slots 8..15 allocated, keep up to 11.
        reserve = 1; reserve_count = 3; step();
        reserve = 1; reserve_count = 3; step();
        check("pf_used8", used_count, 8);
        flush = 1; flush_slot = 11; reserve = 1; step();
        check("pf_used", used_count, 4);
        check("pf_ins", reserved_slots[0], 12);
        wr(0, 14, 32'hDEAD, 0); step();
        check("pf_late", slot_valid, 4'b0000);
        wr(3, 8, 32'h88, 0); reserve = 1; reserve_count = 0; step();

        // Asynchronous reset while entries are in flight.
        #2 reset_n = 1'b0;
        #1;
        mq.delete(); m_ext = 0;
        check("mid_rst_used", used_count, 0);
        check("mid_rst_valid", slot_valid, 0);
        check_all();
        #2 reset_n = 1'b1;

        // Wrap and full.
        for (int r = 0; r < 4; r++) begin
            reserve = 1; reserve_count = (r == 3) ? 2'd0 : 2'd3; step();
        end
        check("full_used", used_count, 13);
        check("full_flag", full, 1);
        reserve = 1; reserve_count = 3; step();
        check("full_ignored", used_count, 13);
        for (int s = 0; s < 13; s += 4) begin
            for (int p = 0; p < 4; p++) if (s + p < 13) wr(p, s + p, 32'h100 + s + p, 0);
            step();
        end
        consume = 1; consume_count = 3; step();
        check("unfull", full, 0);
        check("wrap_slots", reserved_slots, 16'h0FED);
        reserve = 1; reserve_count = 3; step();

        // flush_all beats reserve and consume.
        flush_all = 1; reserve = 1; reserve_count = 3; consume = 1; consume_count = 0; step();
        check("fa_used", used_count, 0);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            int nv = m_nvalid();
            int sz = mq.size();
            int lim = nv;
            reserve = ($urandom_range(0, 1) == 1);
            reserve_count = 2'($urandom_range(0, 3));
            for (int p = 0; p < NW; p++) begin
                int s = (sz > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, sz - 1)].slot
                                                               : int'($urandom_range(0, D - 1));
                if ($urandom_range(0, 1) == 1) wr(p, s, $urandom, $urandom_range(0, 7) == 0);
            end
            if (sz > 0 && $urandom_range(0, 11) == 0) begin
                int fa = $urandom_range(0, sz - 1);
                flush = 1; flush_slot = SW'(mq[fa].slot);
                if (lim > fa + 1) lim = fa + 1;
            end
            if ($urandom_range(0, 40) == 0) flush_all = 1;
            if (lim > 0 && $urandom_range(0, 2) != 0) begin
                consume = 1; consume_count = 2'($urandom_range(0, lim - 1));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
